serial_addsub_unit: RTL and testbench
=====================================

Name: serial_addsub_unit

Overview:
- Multi-cycle, digit-serial add/subtract unit. It generalises the combinational ripple adders and the B-2A subtractor to any width.
- Processes DIGIT bits per clock, LSB first, through a DIGIT-bit adder slice with a registered carry between digits.
- Supports add, subtract, add-with-carry (chained multi-word arithmetic) and b-2a in two passes.
- Sits beside the combinational adders as the area-cheap arithmetic engine, with a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >=2 and a multiple of DIGIT.
- DIGIT, 1, bits processed per clock; N = WIDTH/DIGIT digit beats per pass.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when the unit is not busy
- op  input  2  operation: 00 ADD a+b; 01 SUB a-b; 10 RSUB2 b-2a; 11 ADDC a+b+carry_flag
- a  input  WIDTH  operand A, latched at the accepted start
- b  input  WIDTH  operand B, latched at the accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: result is valid
- s  output  WIDTH  result; holds until the next completion
- c_out  output  1  carry out (1 = no borrow for SUB/RSUB2); also serves as carry_flag for ADDC
- ovf  output  1  two's-complement signed overflow of the full operation

Behaviour:
- Reset (async, any time, including mid-operation): state IDLE; busy=0, done=0, s=0, c_out=0, ovf=0. The partial operation is discarded. The first start after rst deasserts is accepted normally.
- States: IDLE, PASS1, PASS2, DONE.
- Start acceptance:
  - start=1 at an edge in IDLE or DONE latches a, b, op and loads the digit counter to 0.
  - Initial carry: 0 for ADD; 1 for SUB/RSUB2; current c_out for ADDC.
  - Next state is PASS1; busy=1 from the next cycle.
  - start while in PASS1/PASS2 is ignored, with no queueing.
- Per-edge digit processing in PASS1/PASS2:
  - digit_adder adds operand digit x plus digit y (inverted for SUB/RSUB2) plus the carry register.
  - The sum digit shifts into the result register from the MSB end; the carry register updates; the counter increments.
- End of PASS1:
  - After edge N, ADD/SUB/ADDC go to DONE.
  - RSUB2 goes to PASS2: x=b, y=a in PASS1; PASS2 uses x=pass1 result, y=a, carry reset to 1.
  - Pass1 carry c1 and overflow ov1 are saved.
- DONE:
  - Entered after the final edge; done=1 and busy=0 for exactly one cycle.
  - s, c_out and ovf are updated on the same edge that enters DONE.
  - Next state is IDLE, or PASS1 if start=1 (back-to-back operation allowed).
- Latency (start edge to first cycle with done=1):
  - N+1 cycles for ADD/SUB/ADDC.
  - 2N+1 cycles for RSUB2.
  - busy is high for N (or 2N) cycles.
- Results:
  - ADD/SUB/ADDC: c_out = final carry; ovf = carry into MSB XOR carry out of MSB.
  - RSUB2: c_out = c1 & c2 (1 iff b >= 2a unsigned); ovf = ov1 | ov2, which is exact.
  - Result wraps modulo 2^WIDTH.
- Outputs s, c_out and ovf are stable except at the completion edge. The carry_flag seen by ADDC is the c_out of the last completed operation.
- DIGIT=WIDTH is legal: one beat per pass.

Decomposition:
- Shared package (arith_pkg):
  - op encodings OP_ADD/OP_SUB/OP_RSUB2/OP_ADDC;
  - state enum IDLE/PASS1/PASS2/DONE.
- One combinational sub-module, digit_adder:
  - parameter DIGIT;
  - inputs x, y, cin; outputs sum, cout, and c_msb_in (carry into the top bit, used for overflow);
  - built as a ripple of full adders.
- Control FSM, counter and shift registers live in the top module.

Test Plan (WIDTH=16, DIGIT=4, N=4):
- ADD a=0x00FF b=0x0001 -> done 5 cycles after the start edge; s=0x0100, c_out=0, ovf=0; busy high exactly 4 cycles.
- SUB a=0x0005 b=0x0007 -> s=0xFFFE, c_out=0, ovf=0. SUB a=0x0007 b=0x0005 -> s=0x0002, c_out=1.
- RSUB2 a=0x0003 b=0x000A -> done after 9 cycles; s=0x0004, c_out=1. RSUB2 a=0x0006 b=0x000A -> s=0xFFFE, c_out=0.
- ADD 0xFFFF+0x0001 -> s=0x0000, c_out=1; then ADDC a=0 b=0 -> s=0x0001, c_out=0.
- Overflow cases:
  - ADD 0x7FFF+0x0001 -> s=0x8000, ovf=1.
  - RSUB2 b=0x7FFF a=0xFFFF -> s=0x8001, ovf=1.
  - RSUB2 b=0x0010 a=0x0004 -> s=0x0008, ovf=0.
- Control corner cases:
  - start pulses during busy -> ignored, result unchanged.
  - rst asserted at digit 2 -> all outputs 0 immediately, done never pulses.
  - start held high in the DONE cycle -> next operation begins without an IDLE cycle.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the digit-serial add/subtract unit:
// operation encodings and the control state enum.
package arith_pkg;

    // Operation select, matching the 2-bit op input.
    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,   // a + b
        OP_SUB   = 2'b01,   // a - b
        OP_RSUB2 = 2'b10,   // b - 2a, done as (b - a) - a in two passes
        OP_ADDC  = 2'b11    // a + b + carry_flag
    } op_t;

    // Control states of the serial engine.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS1 = 2'b01,
        PASS2 = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Subtracting operations feed the inverted y digit with an initial carry of 1.
    function automatic logic op_inverts_y(input op_t o);
        return (o == OP_SUB) || (o == OP_RSUB2);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder slice: sum = x + y + cin.
// Also exposes the carry into the top bit so the caller can form
// two's-complement overflow as c_msb_in ^ cout.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    // Ripple of full adders, LSB to MSB.
    always_comb begin
        c   = '0;
        sum = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout     = c[DIGIT];
        c_msb_in = c[DIGIT - 1];
    end

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial add/subtract engine. Each beat adds one DIGIT-wide slice
// (LSB first) through digit_adder with the carry held in a register
// between beats. RSUB2 (b - 2a) runs two passes: (b - a), then (that - a).
//
// Handshake: start is sampled on a rising edge only in IDLE or DONE; an
// accepted start raises busy from the next cycle. busy stays high for the
// N (or 2N) beat cycles, then done pulses for exactly one cycle with busy
// low, and s/c_out/ovf update on the edge entering DONE and hold until the
// next completion. start seen during busy is dropped, never queued.
module serial_addsub_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output state_t           dbg_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    op_t              op_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] x_sh;     // x operand, consumed DIGIT bits per beat
    logic [WIDTH-1:0] y_sh;     // y operand, consumed DIGIT bits per beat
    logic [WIDTH-1:0] a_r;      // copy of a for the second RSUB2 pass
    logic [WIDTH-1:0] res;      // result digits enter from the MSB end
    logic             carry;
    logic             c1;       // pass-1 carry of RSUB2
    logic             ov1;      // pass-1 overflow of RSUB2

    logic [DIGIT-1:0] x_dig;
    logic [DIGIT-1:0] y_dig;
    logic [DIGIT-1:0] sum_dig;
    logic             cout_dig;
    logic             c_msb_dig;
    logic [WIDTH-1:0] res_next;
    logic             last_beat;
    logic             beat_ovf;

    assign dbg_state = state;

    // Operand digit selection, result shift and end-of-pass detection.
    always_comb begin
        x_dig     = x_sh[DIGIT-1:0];
        y_dig     = op_inverts_y(op_r) ? ~y_sh[DIGIT-1:0] : y_sh[DIGIT-1:0];
        res_next  = (res >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
        last_beat = (cnt == CW'(N - 1));
        beat_ovf  = c_msb_dig ^ cout_dig;
    end

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x        (x_dig),
        .y        (y_dig),
        .cin      (carry),
        .sum      (sum_dig),
        .cout     (cout_dig),
        .c_msb_in (c_msb_dig)
    );

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_r  <= OP_ADD;
            cnt   <= '0;
            x_sh  <= '0;
            y_sh  <= '0;
            a_r   <= '0;
            res   <= '0;
            carry <= 1'b0;
            c1    <= 1'b0;
            ov1   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_r  <= op_t'(op);
                        x_sh  <= (op_t'(op) == OP_RSUB2) ? b : a;
                        y_sh  <= (op_t'(op) == OP_RSUB2) ? a : b;
                        a_r   <= a;
                        cnt   <= '0;
                        case (op_t'(op))
                            OP_ADD:  carry <= 1'b0;
                            OP_ADDC: carry <= c_out;
                            default: carry <= 1'b1;
                        endcase
                        busy  <= 1'b1;
                        state <= PASS1;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                PASS1: begin
                    x_sh  <= x_sh >> DIGIT;
                    y_sh  <= y_sh >> DIGIT;
                    res   <= res_next;
                    carry <= cout_dig;
                    cnt   <= cnt + CW'(1);
                    if (last_beat) begin
                        if (op_r == OP_RSUB2) begin
                            // Second pass subtracts a again from the pass-1 result.
                            c1    <= cout_dig;
                            ov1   <= beat_ovf;
                            x_sh  <= res_next;
                            y_sh  <= a_r;
                            carry <= 1'b1;
                            cnt   <= '0;
                            state <= PASS2;
                        end else begin
                            s     <= res_next;
                            c_out <= cout_dig;
                            ovf   <= beat_ovf;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                PASS2: begin
                    x_sh  <= x_sh >> DIGIT;
                    y_sh  <= y_sh >> DIGIT;
                    res   <= res_next;
                    carry <= cout_dig;
                    cnt   <= cnt + CW'(1);
                    if (last_beat) begin
                        s     <= res_next;
                        c_out <= c1 & cout_dig;
                        ovf   <= ov1 | beat_ovf;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit (WIDTH=16, DIGIT=4).
module tb_serial_addsub_unit;
    import arith_pkg::*;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;
    state_t       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic model_cf = 1'b0;
    logic [W+1:0] exp_q[$];     // {ovf, c_out, s}

    serial_addsub_unit #(.WIDTH(W), .DIGIT(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // reference model: returns {ovf, c_out, s}
    function automatic logic [W+1:0] model(input logic [1:0] o, input logic [W-1:0] ai,
                                           input logic [W-1:0] bi, input logic cf);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           ri;
        case (o)
            2'b00, 2'b11: begin
                t = {1'b0, ai} + {1'b0, bi} + ((o == 2'b11) ? {{W{1'b0}}, cf} : '0);
                r = t[W-1:0];
                c = t[W];
                v = (ai[W-1] == bi[W-1]) && (r[W-1] != ai[W-1]);
            end
            2'b01: begin
                r = ai - bi;
                c = (ai >= bi);
                v = (ai[W-1] != bi[W-1]) && (r[W-1] != ai[W-1]);
            end
            default: begin
                r  = bi - (ai << 1);
                c  = ({2'b00, bi} >= {1'b0, ai, 1'b0});
                ri = int'($signed(bi)) - 2 * int'($signed(ai));
                v  = (ri > 32767) || (ri < -32768);
            end
        endcase
        return {v, c, r};
    endfunction

    // driver: issue one op, wait for done (sampled on negedge)
    task automatic drive_op(input logic [1:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                            output int lat, output int busy_cyc);
        logic [W+1:0] e;
        @(negedge clk);
        e = model(o, ai, bi, model_cf);
        exp_q.push_back(e);
        model_cf = e[W];
        start = 1'b1; op = o; a = ai; b = bi;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cyc = 0;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                lat = k + 1;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, c_out, ovf} !== 4'b0000 || s !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy%b done%b c%b v%b s=%h expected all 0", busy, done, c_out, ovf, s);
        end
        n_checks++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy%b done%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        int lat, bc;
        logic [W+1:0] e;
        logic [W-1:0] held;
        drive_op(2'b00, 16'h00FF, 16'h0001, lat, bc);
        e = exp_q.pop_front();
        n_checks++;
        if (s !== e[W-1:0] || c_out !== e[W] || ovf !== e[W+1]) begin
            n_fail++;
            $display("FAIL add_result: got s=%h c=%b v=%b expected s=%h c=%b v=%b", s, c_out, ovf, e[W-1:0], e[W], e[W+1]);
        end
        n_checks++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL add_latency: got %0d expected 5", lat);
        end
        n_checks++;
        if (bc != 4) begin
            n_fail++;
            $display("FAIL add_busy_cycles: got %0d expected 4", bc);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add_busy_in_done: got %b expected 0", busy);
        end
        held = s;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || s !== held) begin
            n_fail++;
            $display("FAIL add_done_pulse: got done=%b s=%h expected done=0 s=%h", done, s, held);
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] av[2] = '{16'h0005, 16'h0007};
        logic [W-1:0] bv[2] = '{16'h0007, 16'h0005};
        int lat, bc;
        logic [W+1:0] e;
        for (int i = 0; i < 2; i++) begin
            drive_op(2'b01, av[i], bv[i], lat, bc);
            e = exp_q.pop_front();
            n_checks++;
            if (s !== e[W-1:0] || c_out !== e[W] || ovf !== e[W+1]) begin
                n_fail++;
                $display("FAIL sub_result[%0d]: got s=%h c=%b v=%b expected s=%h c=%b v=%b", i, s, c_out, ovf, e[W-1:0], e[W], e[W+1]);
            end
        end
    endtask

    task automatic test_rsub2();
        logic [W-1:0] av[2] = '{16'h0003, 16'h0006};
        logic [W-1:0] bv[2] = '{16'h000A, 16'h000A};
        int lat, bc;
        logic [W+1:0] e;
        for (int i = 0; i < 2; i++) begin
            drive_op(2'b10, av[i], bv[i], lat, bc);
            e = exp_q.pop_front();
            n_checks++;
            if (s !== e[W-1:0] || c_out !== e[W] || ovf !== e[W+1]) begin
                n_fail++;
                $display("FAIL rsub2_result[%0d]: got s=%h c=%b v=%b expected s=%h c=%b v=%b", i, s, c_out, ovf, e[W-1:0], e[W], e[W+1]);
            end
            n_checks++;
            if (lat != 9 || bc != 8) begin
                n_fail++;
                $display("FAIL rsub2_timing[%0d]: got lat=%0d busy=%0d expected lat=9 busy=8", i, lat, bc);
            end
        end
    endtask

    task automatic test_addc_chain();
        logic [1:0]   ov[2] = '{2'b00, 2'b11};
        logic [W-1:0] av[2] = '{16'hFFFF, 16'h0000};
        logic [W-1:0] bv[2] = '{16'h0001, 16'h0000};
        int lat, bc;
        logic [W+1:0] e;
        for (int i = 0; i < 2; i++) begin
            drive_op(ov[i], av[i], bv[i], lat, bc);
            e = exp_q.pop_front();
            n_checks++;
            if (s !== e[W-1:0] || c_out !== e[W] || ovf !== e[W+1]) begin
                n_fail++;
                $display("FAIL addc_chain[%0d]: got s=%h c=%b v=%b expected s=%h c=%b v=%b", i, s, c_out, ovf, e[W-1:0], e[W], e[W+1]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [1:0]   ov[3] = '{2'b00, 2'b10, 2'b10};
        logic [W-1:0] av[3] = '{16'h7FFF, 16'hFFFF, 16'h0004};
        logic [W-1:0] bv[3] = '{16'h0001, 16'h7FFF, 16'h0010};
        int lat, bc;
        logic [W+1:0] e;
        for (int i = 0; i < 3; i++) begin
            drive_op(ov[i], av[i], bv[i], lat, bc);
            e = exp_q.pop_front();
            n_checks++;
            if (s !== e[W-1:0] || c_out !== e[W] || ovf !== e[W+1]) begin
                n_fail++;
                $display("FAIL overflow[%0d]: got s=%h c=%b v=%b expected s=%h c=%b v=%b", i, s, c_out, ovf, e[W-1:0], e[W], e[W+1]);
            end
        end
    endtask

    task automatic test_start_during_busy();
        logic [W+1:0] e;
        int k;
        @(negedge clk);
        e = model(2'b00, 16'h1234, 16'h1111, model_cf);
        exp_q.push_back(e);
        model_cf = e[W];
        start = 1'b1; op = 2'b00; a = 16'h1234; b = 16'h1111;
        @(negedge clk);
        for (k = 0; k < 100; k++) begin
            if (done) break;
            start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            op = 2'b01;
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            @(negedge clk);
        end
        start = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (k >= 100 || s !== e[W-1:0] || c_out !== e[W] || ovf !== e[W+1]) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got s=%h c=%b v=%b expected s=%h c=%b v=%b", s, c_out, ovf, e[W-1:0], e[W], e[W+1]);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL busy_start_no_queue: got busy=%b done=%b st=%0d expected 0 0 %0d", busy, done, dbg_state, IDLE);
        end
    endtask

    task automatic test_reset_mid_op();
        int pulses = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 16'h0F0F; b = 16'h0101;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, c_out, ovf} !== 4'b0000 || s !== '0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_op: got busy%b done%b c%b v%b s=%h st=%0d expected all 0", busy, done, c_out, ovf, s, dbg_state);
        end
        model_cf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] e;
        int k;
        int lat;
        @(negedge clk);
        e = model(2'b00, 16'h0100, 16'h0023, model_cf);
        exp_q.push_back(e);
        model_cf = e[W];
        e = model(2'b01, 16'h0050, 16'h0060, model_cf);
        exp_q.push_back(e);
        model_cf = e[W];
        start = 1'b1; op = 2'b00; a = 16'h0100; b = 16'h0023;
        @(negedge clk);
        op = 2'b01; a = 16'h0050; b = 16'h0060;
        for (k = 0; k < 100; k++) begin
            if (done) break;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (k >= 100 || s !== e[W-1:0] || c_out !== e[W] || ovf !== e[W+1]) begin
            n_fail++;
            $display("FAIL b2b_first: got s=%h c=%b v=%b expected s=%h c=%b v=%b", s, c_out, ovf, e[W-1:0], e[W], e[W+1]);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_idle: got busy=%b done=%b expected 1 0", busy, done);
        end
        lat = 0;
        for (k = 0; k < 100; k++) begin
            if (done) begin
                lat = k + 1;
                break;
            end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (lat != 5 || s !== e[W-1:0] || c_out !== e[W] || ovf !== e[W+1]) begin
            n_fail++;
            $display("FAIL b2b_second: got lat=%0d s=%h c=%b v=%b expected lat=5 s=%h c=%b v=%b", lat, s, c_out, ovf, e[W-1:0], e[W], e[W+1]);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [1:0] o;
        logic [W+1:0] e;
        for (int i = 0; i < 12; i++) begin
            o = 2'($urandom_range(0, 3));
            drive_op(o, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), lat, bc);
            e = exp_q.pop_front();
            n_checks++;
            if (s !== e[W-1:0] || c_out !== e[W] || ovf !== e[W+1] || lat != ((o == 2'b10) ? 9 : 5)) begin
                n_fail++;
                $display("FAIL random[%0d] op%0d: got s=%h c=%b v=%b lat=%0d expected s=%h c=%b v=%b", i, o, s, c_out, ovf, lat, e[W-1:0], e[W], e[W+1]);
            end
        end
    endtask

    // sequence + final report
    initial begin
        test_reset();
        test_add();
        test_sub();
        test_rsub2();
        test_addc_chain();
        test_overflow();
        test_start_during_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
